// File: rtl/fdivsqrt_otfc_seq.sv
// rtl/fdivsqrt_otfc_seq.sv - sequential on-the-fly converter for the divide/sqrt unit
module fdivsqrt_otfc_seq #(
    parameter int DIVB = 64,
    parameter int LOGR = 2,
    parameter int CNTW = 7
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_start,
    input  logic [DIVB:0]          i_u_init,
    input  logic [DIVB:0]          i_um_init,
    input  logic [CNTW-1:0]        i_num_digits,
    input  logic [(1<<LOGR)-1:0]   i_digit,
    input  logic                   i_digit_valid,
    output logic                   o_digit_ready,
    input  logic                   i_sign_valid,
    input  logic                   i_rem_neg,
    output logic [DIVB:0]          o_result,
    output logic                   o_result_valid,
    input  logic                   i_result_ready,
    output logic                   o_busy
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_RUN       = 2'd1;
    localparam logic [1:0] S_WAIT_SIGN = 2'd2;
    localparam logic [1:0] S_DONE      = 2'd3;

    localparam logic [DIVB:0]   P_INIT  = {{DIVB{1'b0}}, 1'b1} << (DIVB - LOGR);
    localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

    logic [1:0]      r_state;
    logic [DIVB:0]   r_u;
    logic [DIVB:0]   r_um;
    logic [DIVB:0]   r_p;
    logic [CNTW-1:0] r_cnt;
    logic [DIVB:0]   r_result;

    logic [DIVB:0]   w_k1;
    logic [DIVB:0]   w_k2;
    logic [DIVB:0]   w_k3;
    logic [3:0]      w_d4;
    logic [DIVB:0]   w_u_nxt;
    logic [DIVB:0]   w_um_nxt;
    logic            w_accept;

    // Position masks for the digit currently being appended; they vanish once P shifts out.
    assign w_k1     = r_p;
    assign w_k2     = r_p << 1;
    assign w_k3     = w_k1 | w_k2;
    assign w_d4     = 4'(i_digit);
    assign w_accept = (r_state == S_RUN) && i_digit_valid;

    assign o_digit_ready  = (r_state == S_RUN);
    assign o_result_valid = (r_state == S_DONE);
    assign o_busy         = (r_state != S_IDLE);
    assign o_result       = r_result;

    // Next U/UM for the presented digit; higher digit bits win if more than one is set.
    always_comb begin
        w_u_nxt  = r_u;
        w_um_nxt = r_um;
        if (LOGR == 2) begin
            if (w_d4[3]) begin
                w_u_nxt  = r_u | w_k2;
                w_um_nxt = r_u | w_k1;
            end else if (w_d4[2]) begin
                w_u_nxt  = r_u | w_k1;
                w_um_nxt = r_u;
            end else if (w_d4[1]) begin
                w_u_nxt  = r_um | w_k3;
                w_um_nxt = r_um | w_k2;
            end else if (w_d4[0]) begin
                w_u_nxt  = r_um | w_k2;
                w_um_nxt = r_um | w_k1;
            end else begin
                w_um_nxt = r_um | w_k3;
            end
        end else begin
            if (w_d4[1]) begin
                w_u_nxt  = r_u | w_k1;
                w_um_nxt = r_u;
            end else if (w_d4[0]) begin
                w_u_nxt  = r_um | w_k1;
            end else begin
                w_um_nxt = r_um | w_k1;
            end
        end
    end

    // Control FSM and datapath registers; start aborts whatever is in flight.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= S_IDLE;
            r_u      <= '0;
            r_um     <= '0;
            r_p      <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else if (i_start) begin
            r_u     <= i_u_init;
            r_um    <= i_um_init;
            r_p     <= P_INIT;
            r_cnt   <= i_num_digits;
            r_state <= (i_num_digits != '0) ? S_RUN : S_WAIT_SIGN;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_accept) begin
                        r_u   <= w_u_nxt;
                        r_um  <= w_um_nxt;
                        r_p   <= r_p >> LOGR;
                        r_cnt <= r_cnt - CNT_ONE;
                        if (r_cnt == CNT_ONE) begin
                            r_state <= S_WAIT_SIGN;
                        end
                    end
                end
                S_WAIT_SIGN: begin
                    if (i_sign_valid) begin
                        r_result <= i_rem_neg ? r_um : r_u;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (i_result_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fdivsqrt_otfc_seq.sv
// tb/tb_fdivsqrt_otfc_seq.sv - self-checking bench for fdivsqrt_otfc_seq in radix 4 and radix 2
module tb_fdivsqrt_otfc_seq;

    localparam int DIVB = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       start4, start2;
    logic [8:0] u_init, um_init;
    logic [6:0] num_digits;
    logic [3:0] digit4;
    logic [1:0] digit2;
    logic       digit_valid, sign_valid, rem_neg, result_ready;
    logic       rdy4, rdy2, rv4, rv2, busy4, busy2;
    logic [8:0] res4, res2;

    int checks   = 0;
    int failures = 0;
    int dv[0:15];

    always #5 clk = ~clk;

    fdivsqrt_otfc_seq #(.DIVB(DIVB), .LOGR(2), .CNTW(7)) dut4 (
        .i_clk(clk), .i_reset(reset), .i_start(start4), .i_u_init(u_init), .i_um_init(um_init),
        .i_num_digits(num_digits), .i_digit(digit4), .i_digit_valid(digit_valid), .o_digit_ready(rdy4),
        .i_sign_valid(sign_valid), .i_rem_neg(rem_neg), .o_result(res4), .o_result_valid(rv4),
        .i_result_ready(result_ready), .o_busy(busy4)
    );

    fdivsqrt_otfc_seq #(.DIVB(DIVB), .LOGR(1), .CNTW(7)) dut2 (
        .i_clk(clk), .i_reset(reset), .i_start(start2), .i_u_init(u_init), .i_um_init(um_init),
        .i_num_digits(num_digits), .i_digit(digit2), .i_digit_valid(digit_valid), .o_digit_ready(rdy2),
        .i_sign_valid(sign_valid), .i_rem_neg(rem_neg), .o_result(res2), .o_result_valid(rv2),
        .i_result_ready(result_ready), .o_busy(busy2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic f_rdy(input bit r4);
        return r4 ? rdy4 : rdy2;
    endfunction

    function automatic logic f_rv(input bit r4);
        return r4 ? rv4 : rv2;
    endfunction

    function automatic logic [8:0] f_res(input bit r4);
        return r4 ? res4 : res2;
    endfunction

    function automatic logic [3:0] enc(input bit r4, input int v);
        if (r4) begin
            case (v)
                2:       return 4'b1000;
                1:       return 4'b0100;
                -1:      return 4'b0010;
                -2:      return 4'b0001;
                default: return 4'b0000;
            endcase
        end
        case (v)
            1:       return 4'b0010;
            -1:      return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    // Arithmetic reference: U = u0 + sum(d_i * r^-i), UM = U - one unit of the last digit position.
    function automatic logic [8:0] model(input bit r4, input logic [8:0] u0, input logic [8:0] um0,
                                         input int n, input bit neg);
        int lg = r4 ? 2 : 1;
        int u  = int'(u0);
        int w  = 0;
        if (n == 0) return neg ? um0 : u0;
        for (int i = 1; i <= n; i++) begin
            w = (DIVB - lg * i >= 0) ? (1 << (DIVB - lg * i)) : 0;
            u += dv[i-1] * w;
        end
        return neg ? 9'(u - w) : 9'(u);
    endfunction

    task automatic do_op(input string tag, input bit r4, input logic [8:0] u0, input logic [8:0] um0,
                         input int n, input bit neg, input bit gaps, input int hold, input bit drain,
                         input logic [8:0] exp);
        logic [3:0] e;
        u_init = u0;
        um_init = um0;
        num_digits = 7'(n);
        if (r4) start4 = 1'b1; else start2 = 1'b1;
        step();
        start4 = 1'b0;
        start2 = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (gaps && ($urandom_range(0, 1) == 1)) begin
                digit_valid = 1'b0;
                digit4 = 4'b1000;
                digit2 = 2'b10;
                step();
                chk({tag, "_stall_rdy"}, 64'(f_rdy(r4)), 64'd1);
            end
            e = enc(r4, dv[i]);
            digit4 = e;
            digit2 = e[1:0];
            digit_valid = 1'b1;
            step();
        end
        digit_valid = 1'b0;
        chk({tag, "_wait_rdy"}, 64'(f_rdy(r4)), 64'd0);
        sign_valid = 1'b1;
        rem_neg = neg;
        step();
        sign_valid = 1'b0;
        chk({tag, "_rv"}, 64'(f_rv(r4)), 64'd1);
        chk({tag, "_res"}, 64'(f_res(r4)), 64'(exp));
        for (int h = 0; h < hold; h++) begin
            step();
            chk({tag, "_hold_rv"}, 64'(f_rv(r4)), 64'd1);
            chk({tag, "_hold_res"}, 64'(f_res(r4)), 64'(exp));
        end
        if (drain) begin
            result_ready = 1'b1;
            step();
            result_ready = 1'b0;
            chk({tag, "_drop_rv"}, 64'(f_rv(r4)), 64'd0);
            chk({tag, "_keep_res"}, 64'(f_res(r4)), 64'(exp));
        end
    endtask

    initial begin
        logic [8:0] ru, exp;
        logic [3:0] e;
        bit r4, neg;
        int n;

        reset = 1'b1;
        start4 = 1'b0; start2 = 1'b0;
        u_init = '0; um_init = '0; num_digits = '0;
        digit4 = '0; digit2 = '0;
        digit_valid = 1'b0; sign_valid = 1'b0; rem_neg = 1'b0; result_ready = 1'b0;
        step();
        step();
        chk("rst_rdy4", 64'(rdy4), 64'd0);
        chk("rst_busy4", 64'(busy4), 64'd0);
        chk("rst_rv4", 64'(rv4), 64'd0);
        chk("rst_res4", 64'(res4), 64'd0);
        chk("rst_busy2", 64'(busy2), 64'd0);
        chk("rst_res2", 64'(res2), 64'd0);
        reset = 1'b0;
        step();

        // Radix-4 worked examples from inits of zero.
        dv[0] = 2; dv[1] = 1;
        do_op("r4_p2p1_u", 1'b1, 9'h000, 9'h000, 2, 1'b0, 1'b0, 0, 1'b1, 9'h090);
        do_op("r4_p2p1_um", 1'b1, 9'h000, 9'h000, 2, 1'b1, 1'b0, 0, 1'b1, 9'h080);
        dv[0] = 2; dv[1] = -1;
        do_op("r4_p2m1_u", 1'b1, 9'h000, 9'h000, 2, 1'b0, 1'b1, 0, 1'b1, 9'h070);
        do_op("r4_p2m1_um", 1'b1, 9'h000, 9'h000, 2, 1'b1, 1'b1, 0, 1'b1, 9'h060);

        // Radix-2 worked example.
        dv[0] = 1; dv[1] = -1; dv[2] = 0;
        do_op("r2_um", 1'b0, 9'h000, 9'h000, 3, 1'b1, 1'b0, 0, 1'b1, 9'h020);
        do_op("r2_u", 1'b0, 9'h000, 9'h000, 3, 1'b0, 1'b1, 0, 1'b1, 9'h040);

        // Zero digits: straight to waiting for the sign.
        ru = 9'($urandom);
        do_op("n0_r4", 1'b1, ru, 9'h0a5, 0, 1'b0, 1'b0, 0, 1'b1, ru);
        do_op("n0_r2", 1'b0, 9'h033, ru, 0, 1'b1, 1'b0, 0, 1'b1, ru);

        // Digits past the last position: masks are zero, only the U/UM selection applies.
        for (int i = 0; i < 8; i++) dv[i] = int'($urandom_range(0, 2)) - 1;
        dv[0] = 1;
        exp = model(1'b0, 9'h100, 9'h000, 8, 1'b1);
        dv[8] = -1;
        do_op("pz_m1", 1'b0, 9'h100, 9'h000, 9, 1'b0, 1'b0, 0, 1'b1, exp);
        exp = model(1'b0, 9'h100, 9'h000, 8, 1'b0);
        dv[8] = 1;
        do_op("pz_p1", 1'b0, 9'h100, 9'h000, 9, 1'b1, 1'b0, 0, 1'b1, exp);

        // Start during RUN restarts with the new inits.
        u_init = 9'h1ff; um_init = 9'h1ff; num_digits = 7'd3;
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        digit4 = 4'b1000; digit_valid = 1'b1;
        step();
        digit_valid = 1'b0;
        chk("abort_in_run", 64'(rdy4), 64'd1);
        dv[0] = -1; dv[1] = 2; dv[2] = 0;
        do_op("abort_new", 1'b1, 9'h100, 9'h000, 3, 1'b0, 1'b0, 0, 1'b1,
              model(1'b1, 9'h100, 9'h000, 3, 1'b0));

        // Result held while the consumer stalls, then start wins over result_ready.
        dv[0] = -2; dv[1] = 1; dv[2] = -1; dv[3] = 2;
        exp = model(1'b1, 9'h100, 9'h000, 4, 1'b1);
        do_op("hold", 1'b1, 9'h100, 9'h000, 4, 1'b1, 1'b0, 10, 1'b0, exp);
        ru = 9'($urandom);
        u_init = ru; um_init = 9'h000; num_digits = 7'd0;
        start4 = 1'b1; result_ready = 1'b1;
        step();
        start4 = 1'b0; result_ready = 1'b0;
        chk("start_rr_rv", 64'(rv4), 64'd0);
        chk("start_rr_busy", 64'(busy4), 64'd1);
        chk("start_rr_rdy", 64'(rdy4), 64'd0);
        sign_valid = 1'b1; rem_neg = 1'b0;
        step();
        sign_valid = 1'b0;
        chk("start_rr_res", 64'(res4), 64'(ru));
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
        chk("start_rr_idle", 64'(busy4), 64'd0);

        // Reset mid-RUN.
        u_init = 9'h100; um_init = 9'h000; num_digits = 7'd3;
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        digit4 = 4'b0100; digit_valid = 1'b1;
        step();
        digit_valid = 1'b0;
        reset = 1'b1;
        step();
        chk("rst_run_rdy", 64'(rdy4), 64'd0);
        chk("rst_run_busy", 64'(busy4), 64'd0);
        chk("rst_run_rv", 64'(rv4), 64'd0);
        reset = 1'b0;
        step();

        // Reset in DONE clears the held result.
        dv[0] = 2; dv[1] = 2;
        do_op("pre_rst_done", 1'b1, 9'h100, 9'h000, 2, 1'b0, 1'b0, 0, 1'b0,
              model(1'b1, 9'h100, 9'h000, 2, 1'b0));
        reset = 1'b1;
        step();
        chk("rst_done_rv", 64'(rv4), 64'd0);
        chk("rst_done_res", 64'(res4), 64'd0);
        chk("rst_done_busy", 64'(busy4), 64'd0);
        reset = 1'b0;
        step();

        // Randomised operations against the arithmetic model.
        for (int t = 0; t < 24; t++) begin
            r4  = ($urandom_range(0, 1) == 1);
            n   = r4 ? int'($urandom_range(1, 4)) : int'($urandom_range(1, 8));
            neg = ($urandom_range(0, 1) == 1);
            for (int i = 0; i < n; i++) begin
                dv[i] = r4 ? int'($urandom_range(0, 4)) - 2 : int'($urandom_range(0, 2)) - 1;
            end
            exp = model(r4, 9'h100, 9'h000, n, neg);
            do_op("rand", r4, 9'h100, 9'h000, n, neg, ($urandom_range(0, 1) == 1), 0, 1'b1, exp);
        end

        e = 4'b0;
        digit4 = e;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
